pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
// - Parametrised, pipelined add/subtract unit; successor to the combinational 64-bit Adder.
// - Used in the datapath (PC/branch-target and ALU paths), where a full-width carry chain limits clock rate.
// - Splits the carry chain into STAGES chunks, one register per chunk, with valid/ready flow control.
// - Produces NZCV-style flags: carry, overflow, zero.
// PARAMETERS
// - WIDTH  64 : operand/result width in bits.
// - STAGES 4  : pipeline depth = number of carry-chain chunks.
//   WIDTH % STAGES must be 0; CHUNK = WIDTH/STAGES.
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous reset, active-low
// flush      in   1      synchronous kill of all in-flight operations
// in_valid   in   1      a/b/sub valid this cycle
// in_ready   out  1      unit can accept an operation this cycle
// a          in   WIDTH  operand A
// b          in   WIDTH  operand B
// sub        in   1      0: a+b; 1: a-b (a + ~b + 1)
// out_valid  out  1      result/flags valid
// out_ready  in   1      consumer accepts result
// out        out  WIDTH  sum/difference, modulo 2^WIDTH
// carry_out  out  1      carry out of MSB (for sub: 1 = no borrow)
// overflow   out  1      signed overflow
// zero       out  1      out == 0
// BEHAVIOUR
// - Reset (rst_n=0, async): all stage valid bits, out_valid, out, carry_out, overflow, zero = 0.
//   Operations in flight are discarded; in_ready = 1 after reset.
// - Advance enable: adv = !out_valid || out_ready. When adv=0, every stage holds (global stall).
//   in_ready = adv (combinational from out_ready). Bubbles are not collapsed.
// - Transfer: an input is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
// - Stage k (0..STAGES-1) adds chunk k of a and b' (b' = sub ? ~b : b) plus the carry registered from stage k-1.
//   Stage 0 carry-in = sub. Upper operand chunks are delayed alongside; lower result chunks are carried forward.
// - Latency: exactly STAGES cycles from acceptance to out_valid with out_ready held high.
//   Throughput: 1 operation per cycle.
// - Flags are computed in the last stage:
//   - carry_out = carry out of bit WIDTH-1.
//   - overflow = (a[MSB] == b'[MSB]) && (out[MSB] != a[MSB]).
//   - zero = ~|out.
// - out/flags are stable while out_valid && !out_ready; they may change only on a consume or an advance.
// - flush=1: all valid bits clear on the next edge, and an input presented that cycle is not accepted
//   (in_ready forced 0 while flush=1). flush overrides stall. Datapath registers need not clear.
// - Simultaneous consume and accept in the same cycle: both occur, with no lost or duplicated operation.
// - STAGES=1: single registered adder with latency 1; same handshake.
// - Ordering: results emerge strictly in acceptance order.
// TESTING (WIDTH=64, STAGES=4 unless noted)
// 1. a=0x1234567890ABCDEF, b=0xFEDCBA0987654321, sub=0, out_ready=1
//    -> after 4 cycles: out=0x1111108218111110, carry_out=1, overflow=0, zero=0.
// 2. a=0x7FFFFFFFFFFFFFFF, b=1, sub=0 -> out=0x8000000000000000, overflow=1, carry_out=0, zero=0.
// 3. a=5, b=5, sub=1 -> out=0, zero=1, carry_out=1, overflow=0.
//    a=0, b=1, sub=1 -> out=0xFFFFFFFFFFFFFFFF, carry_out=0, overflow=0.
// 4. Stream 8 back-to-back operations (a=i, b=i<<32); hold out_ready=0 for 3 cycles mid-stream
//    -> in_ready drops while stalled, all 8 results emerge in order with correct values, no duplicates.
// 5. 3 operations in flight, assert flush for 1 cycle -> none of them appears on out_valid;
//    the next accepted operation emerges with latency 4.
// 6. Drop rst_n asynchronously mid-stream -> out_valid=0 and all outputs 0 immediately;
//    after release, a new operation completes normally.
//    Repeat tests 1-3 with STAGES=1 and STAGES=8 -> identical results, latency = STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES chunks, one
// register stage per chunk, with valid/ready flow control and carry/overflow/zero flags.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] bEff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !flush;
  assign accept   = in_valid && in_ready;
  assign bEff     = sub ? ~b : b;

  // Stage k owns bits [k*CHUNK +: CHUNK]: operands shrink and the partial sum grows as they move up.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      aIn;
    logic [REM-1:0]      bIn;
    logic                cIn;
    logic                vIn;
    logic [CHUNK:0]      chunkSum;
    logic [LO+CHUNK-1:0] sumNext;
    logic [LO+CHUNK-1:0] sumQ;
    logic                cQ;
    logic                vQ;

    if (k == 0) begin : g_head
      assign aIn     = a;
      assign bIn     = bEff;
      assign cIn     = sub;
      assign vIn     = accept;
      assign sumNext = chunkSum[CHUNK-1:0];
    end else begin : g_body
      assign aIn     = stg[k-1].g_fwd.aQ;
      assign bIn     = stg[k-1].g_fwd.bQ;
      assign cIn     = stg[k-1].cQ;
      assign vIn     = stg[k-1].vQ;
      assign sumNext = {chunkSum[CHUNK-1:0], stg[k-1].sumQ};
    end

    assign chunkSum = {1'b0, aIn[CHUNK-1:0]} + {1'b0, bIn[CHUNK-1:0]} + (CHUNK+1)'(cIn);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vQ   <= 1'b0;
        cQ   <= 1'b0;
        sumQ <= '0;
      end else begin
        if (flush) begin
          vQ <= 1'b0;
        end else if (adv) begin
          vQ <= vIn;
        end
        if (adv) begin
          cQ   <= chunkSum[CHUNK];
          sumQ <= sumNext;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] aQ;
      logic [REM-CHUNK-1:0] bQ;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          aQ <= '0;
          bQ <= '0;
        end else if (adv) begin
          aQ <= aIn[REM-1:CHUNK];
          bQ <= bIn[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovfQ;
      logic zeroQ;

      // Top chunk still holds the operand sign bits, so overflow is resolved here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovfQ  <= 1'b0;
          zeroQ <= 1'b0;
        end else if (adv) begin
          ovfQ  <= (aIn[CHUNK-1] == bIn[CHUNK-1]) && (chunkSum[CHUNK-1] != aIn[CHUNK-1]);
          zeroQ <= ~|sumNext;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vQ;
  assign out       = stg[STAGES-1].sumQ;
  assign carry_out = stg[STAGES-1].cQ;
  assign overflow  = stg[STAGES-1].g_last.ovfQ;
  assign zero      = stg[STAGES-1].g_last.zeroQ;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: three instances (STAGES 1, 4, 8) share one
// input stream; flow-control scenarios are checked on the STAGES=4 instance.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        sub;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;

  logic        irA [3];
  logic        ovA [3];
  logic        coA [3];
  logic        vfA [3];
  logic        zA  [3];
  logic [63:0] oA  [3];

  int checks = 0;
  int errors = 0;

  localparam int DEPTH [3] = '{1, 4, 8};

  localparam logic [63:0] VA [4] = '{64'h1234567890ABCDEF, 64'h7FFFFFFFFFFFFFFF, 64'd5, 64'd0};
  localparam logic [63:0] VB [4] = '{64'hFEDCBA0987654321, 64'd1, 64'd5, 64'd1};
  localparam logic        VS [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [63:0] VO [4] = '{64'h1111108218111110, 64'h8000000000000000, 64'd0,
                                     64'hFFFFFFFFFFFFFFFF};
  localparam logic        VC [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic        VV [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        VZ [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(64), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(irA[0]),
    .a(a), .b(b), .sub(sub), .out_valid(ovA[0]), .out_ready(out_ready), .out(oA[0]),
    .carry_out(coA[0]), .overflow(vfA[0]), .zero(zA[0]));

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(irA[1]),
    .a(a), .b(b), .sub(sub), .out_valid(ovA[1]), .out_ready(out_ready), .out(oA[1]),
    .carry_out(coA[1]), .overflow(vfA[1]), .zero(zA[1]));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(irA[2]),
    .a(a), .b(b), .sub(sub), .out_valid(ovA[2]), .out_ready(out_ready), .out(oA[2]),
    .carry_out(coA[2]), .overflow(vfA[2]), .zero(zA[2]));

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ovA[d] !== 1'b0 || oA[d] !== 64'd0 || coA[d] !== 1'b0 || vfA[d] !== 1'b0 || zA[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs s%0d: got v=%b out=%h c=%b o=%b z=%b, expected all 0",
                 DEPTH[d], ovA[d], oA[d], coA[d], vfA[d], zA[d]);
      end
      checks++;
      if (irA[d] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_in_ready s%0d: got %b expected 1", DEPTH[d], irA[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    drain();
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      a = VA[v]; b = VB[v]; sub = VS[v]; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
        if (n > 1) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (ovA[d] !== (n == DEPTH[d])) begin
            errors++;
            $display("[TB] FAIL vec%0d_valid s%0d cycle%0d: got %b expected %b",
                     v, DEPTH[d], n, ovA[d], (n == DEPTH[d]));
          end
          if (n == DEPTH[d]) begin
            checks++;
            if (oA[d] !== VO[v]) begin
              errors++;
              $display("[TB] FAIL vec%0d_out s%0d: got %h expected %h", v, DEPTH[d], oA[d], VO[v]);
            end
            checks++;
            if (coA[d] !== VC[v] || vfA[d] !== VV[v] || zA[d] !== VZ[v]) begin
              errors++;
              $display("[TB] FAIL vec%0d_flags s%0d: got c=%b o=%b z=%b expected c=%b o=%b z=%b",
                       v, DEPTH[d], coA[d], vfA[d], zA[d], VC[v], VV[v], VZ[v]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    logic [63:0] expVal;
    drain();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (sent < 8);
      a = 64'(sent); b = 64'(sent) << 32; sub = 1'b0;
      #1;
      if (!out_ready) begin
        checks++;
        if (irA[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_stall_in_ready cycle%0d: got %b expected 0", cyc, irA[1]);
        end
      end
      if (ovA[1] && out_ready) begin
        expVal = (64'(got) << 32) | 64'(got);
        checks++;
        if (oA[1] !== expVal) begin
          errors++;
          $display("[TB] FAIL b2b_out%0d: got %h expected %h", got, oA[1], expVal);
        end
        got++;
      end
      if (in_valid && irA[1]) sent++;
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results expected 8", got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (ovA[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_extra cycle%0d: got out_valid %b expected 0", n, ovA[1]);
      end
    end
  endtask

  task automatic test_flush();
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 64'(100 + i); b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1; a = 64'd555; in_valid = 1'b1;
    #1;
    checks++;
    if (irA[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_in_ready: got %b expected 0", irA[1]);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (ovA[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_killed cycle%0d: got out_valid %b expected 0", n, ovA[1]);
      end
      @(negedge clk);
    end
    a = 64'h10; b = 64'h20; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (ovA[1] !== (n == 4)) begin
        errors++;
        $display("[TB] FAIL flush_latency cycle%0d: got %b expected %b", n, ovA[1], (n == 4));
      end
    end
    checks++;
    if (oA[1] !== 64'h30) begin
      errors++;
      $display("[TB] FAIL flush_next_out: got %h expected 0000000000000030", oA[1]);
    end
  endtask

  task automatic test_async_reset();
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    a = 64'h8000000000000000; b = 64'h8000000000000001; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 64'd7; b = 64'd8;
    repeat (5) @(negedge clk);
    checks++;
    if (ovA[1] !== 1'b1 || oA[1] !== 64'd1 || coA[1] !== 1'b1 || vfA[1] !== 1'b1 || zA[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_pre: got v=%b out=%h c=%b o=%b z=%b expected v=1 out=1 c=1 o=1 z=0",
               ovA[1], oA[1], coA[1], vfA[1], zA[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ovA[1] !== 1'b0 || oA[1] !== 64'd0 || coA[1] !== 1'b0 || vfA[1] !== 1'b0 || zA[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_outputs: got v=%b out=%h c=%b o=%b z=%b expected all 0",
               ovA[1], oA[1], coA[1], vfA[1], zA[1]);
    end
    checks++;
    if (irA[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL areset_in_ready: got %b expected 1", irA[1]);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    a = 64'd3; b = 64'd9; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) @(negedge clk);
      checks++;
      if (ovA[1] !== (n == 4)) begin
        errors++;
        $display("[TB] FAIL areset_latency cycle%0d: got %b expected %b", n, ovA[1], (n == 4));
      end
    end
    checks++;
    if (oA[1] !== 64'hFFFFFFFFFFFFFFFA || coA[1] !== 1'b0 || vfA[1] !== 1'b0 || zA[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_after_op: got out=%h c=%b o=%b z=%b expected fffffffffffffffa c=0 o=0 z=0",
               oA[1], coA[1], vfA[1], zA[1]);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
